// File: rtl/fp_pkg.sv
// Shared widths and the normalised-result record for the approximate-FP datapath.
package fp_pkg;

    localparam int FP_MANT_W = 16;
    localparam int FP_EXP_W  = 8;
    localparam int FP_LZ_W   = $clog2(FP_MANT_W);

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_MANT_W-1:0] mant;
        logic                 zero;
        logic                 uflow;
    } norm_res_t;

endpackage

// File: rtl/lzc_2bitaligned_bigendian.sv
// Leading-zero counter built as a tree of 2-bit leaves, MSB-first; valid_o=0 when data_i is all zero.
module lzc_2bitaligned_bigendian #(
    parameter int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             valid_o
);

    localparam int NP = WIDTH / 2;

    always_comb begin
        logic [NP-1:0]    v;
        logic [CNT_W-1:0] c [NP];
        for (int i = 0; i < NP; i++) begin
            v[i]    = data_i[WIDTH-1-2*i] | data_i[WIDTH-2-2*i];
            c[i]    = '0;
            c[i][0] = ~data_i[WIDTH-1-2*i];
        end
        // Each level merges neighbour pairs in place; a zero left half adds 2^l to the right count.
        for (int l = 1; l < CNT_W; l++) begin
            for (int j = 0; j < (NP >> l); j++) begin
                c[j] = v[2*j] ? c[2*j] : (c[2*j+1] | (CNT_W'(1) << l));
                v[j] = v[2*j] | v[2*j+1];
            end
        end
        cnt_o   = c[0];
        valid_o = v[0];
    end

endmodule

// File: rtl/fp_norm_pipe.sv
// Two-stage normaliser: S1 registers operands plus leading-zero count, S2 shifts and
// adjusts the exponent, flushing to zero when the exponent would underflow.
module fp_norm_pipe #(
    parameter int MANT_W = fp_pkg::FP_MANT_W,
    parameter int EXP_W  = fp_pkg::FP_EXP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-1:0] out_mant,
    output logic              out_zero,
    output logic              out_uflow
);

    import fp_pkg::*;

    localparam int LZ_W = $clog2(MANT_W);

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
        logic              zero;
        logic              uflow;
    } res_t;

    logic              s1_v_q,    s1_v_d;
    logic              s1_sign_q, s1_sign_d;
    logic [EXP_W-1:0]  s1_exp_q,  s1_exp_d;
    logic [MANT_W-1:0] s1_mant_q, s1_mant_d;
    logic [LZ_W-1:0]   s1_lz_q,   s1_lz_d;
    logic              s1_nz_q,   s1_nz_d;
    logic              s2_v_q,    s2_v_d;
    res_t              out_q,     out_d;

    logic [LZ_W-1:0]   lz_cnt;
    logic              lz_nz;
    logic              s1_load;
    logic              s2_load;
    logic [MANT_W-1:0] mant_sh;
    logic [EXP_W-1:0]  lz_ext;
    res_t              res;

    lzc_2bitaligned_bigendian #(.WIDTH(MANT_W)) u_lzc (
        .data_i  (in_mant),
        .cnt_o   (lz_cnt),
        .valid_o (lz_nz)
    );

    always_comb begin
        s2_load = !s2_v_q || out_ready;
        s1_load = !s1_v_q || s2_load;

        mant_sh = s1_mant_q;
        for (int k = 0; k < LZ_W; k++) begin
            if (s1_lz_q[k]) begin
                mant_sh = mant_sh << (1 << k);
            end
        end
        lz_ext = EXP_W'(s1_lz_q);

        res.sign  = s1_sign_q;
        res.exp   = '0;
        res.mant  = '0;
        res.zero  = 1'b0;
        res.uflow = 1'b0;
        if (!s1_nz_q) begin
            res.zero = 1'b1;
        end else if (lz_ext < s1_exp_q) begin
            res.mant = mant_sh;
            res.exp  = s1_exp_q - lz_ext;
        end else begin
            res.uflow = 1'b1;
        end

        s1_v_d    = s1_v_q;
        s1_sign_d = s1_sign_q;
        s1_exp_d  = s1_exp_q;
        s1_mant_d = s1_mant_q;
        s1_lz_d   = s1_lz_q;
        s1_nz_d   = s1_nz_q;
        s2_v_d    = s2_v_q;
        out_d     = out_q;

        if (s1_load) begin
            s1_v_d = in_valid;
            if (in_valid) begin
                s1_sign_d = in_sign;
                s1_exp_d  = in_exp;
                s1_mant_d = in_mant;
                s1_lz_d   = lz_cnt;
                s1_nz_d   = lz_nz;
            end
        end

        // Output data only moves when a real beat arrives, so it holds through stalls and bubbles.
        if (s2_load) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                out_d = res;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_exp_q  <= '0;
            s1_mant_q <= '0;
            s1_lz_q   <= '0;
            s1_nz_q   <= 1'b0;
            s2_v_q    <= 1'b0;
            out_q     <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_sign_q <= s1_sign_d;
            s1_exp_q  <= s1_exp_d;
            s1_mant_q <= s1_mant_d;
            s1_lz_q   <= s1_lz_d;
            s1_nz_q   <= s1_nz_d;
            s2_v_q    <= s2_v_d;
            out_q     <= out_d;
        end
    end

    assign in_ready  = s1_load;
    assign out_valid = s2_v_q;
    assign out_sign  = out_q.sign;
    assign out_exp   = out_q.exp;
    assign out_mant  = out_q.mant;
    assign out_zero  = out_q.zero;
    assign out_uflow = out_q.uflow;

endmodule

// File: tb/tb_fp_norm_pipe.sv
// Directed bench for fp_norm_pipe at MANT_W=16, EXP_W=8: values, boundaries, stalls and reset.
module tb_fp_norm_pipe;

    import fp_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [15:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [15:0] out_mant;
    logic        out_zero;
    logic        out_uflow;

    int tests_run    = 0;
    int tests_failed = 0;

    fp_norm_pipe #(.MANT_W(16), .EXP_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_mant  (out_mant),
        .out_zero  (out_zero),
        .out_uflow (out_uflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one beat with out_ready=1; returns out_valid one cycle after acceptance,
    // and out_valid plus result two cycles after acceptance.
    task automatic run_beat(input logic s, input logic [7:0] e, input logic [15:0] m,
                            output logic v_early, output logic v_late, output norm_res_t got);
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sign   = s;
        in_exp    = e;
        in_mant   = m;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #4;
        v_early = out_valid;
        @(posedge clk); #5;
        v_late = out_valid;
        got    = {out_sign, out_exp, out_mant, out_zero, out_uflow};
    endtask

    task automatic test_reset();
        norm_res_t got;
        got = {out_sign, out_exp, out_mant, out_zero, out_uflow};
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || got !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: out_valid=%b in_ready=%b out=%h, required 0 1 0",
                     out_valid, in_ready, got);
        end
    endtask

    task automatic test_values();
        logic       ve, vl;
        norm_res_t  got;
        logic       s_t  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [7:0] e_t  [8] = '{8'd100, 8'd100, 8'd50, 8'd10, 8'd16, 8'd15, 8'd0, 8'd200};
        logic [15:0] m_t [8] = '{16'h8000, 16'h0013, 16'h0000, 16'h0001,
                                 16'h0001, 16'h0001, 16'h8000, 16'h0100};
        norm_res_t  x_t  [8];
        x_t[0] = '{sign:1'b0, exp:8'd100, mant:16'h8000, zero:1'b0, uflow:1'b0};
        x_t[1] = '{sign:1'b0, exp:8'd89,  mant:16'h9800, zero:1'b0, uflow:1'b0};
        x_t[2] = '{sign:1'b1, exp:8'd0,   mant:16'h0000, zero:1'b1, uflow:1'b0};
        x_t[3] = '{sign:1'b0, exp:8'd0,   mant:16'h0000, zero:1'b0, uflow:1'b1};
        x_t[4] = '{sign:1'b1, exp:8'd1,   mant:16'h8000, zero:1'b0, uflow:1'b0};
        x_t[5] = '{sign:1'b0, exp:8'd0,   mant:16'h0000, zero:1'b0, uflow:1'b1};
        x_t[6] = '{sign:1'b0, exp:8'd0,   mant:16'h0000, zero:1'b0, uflow:1'b1};
        x_t[7] = '{sign:1'b1, exp:8'd193, mant:16'h8000, zero:1'b0, uflow:1'b0};
        for (int i = 0; i < 8; i++) begin
            run_beat(s_t[i], e_t[i], m_t[i], ve, vl, got);
            tests_run++;
            if (ve !== 1'b0 || vl !== 1'b1) begin
                tests_failed++;
                $display("FAIL latency[%0d]: valid after 1 cycle=%b after 2=%b, required 0 1", i, ve, vl);
            end
            tests_run++;
            if (got !== x_t[i]) begin
                tests_failed++;
                $display("FAIL value[%0d] mant=%h exp=%0d: got %h, required %h",
                         i, m_t[i], e_t[i], got, x_t[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] mants [8] = '{16'h8000, 16'h4000, 16'h0013, 16'h0001,
                                   16'h0000, 16'h00F0, 16'h1234, 16'h0ABC};
        norm_res_t exp_s [8];
        norm_res_t got, held;
        logic      exp_rdy;
        logic      stalled = 1'b0;
        int        in_idx  = 0;
        int        out_idx = 0;
        int        cyc     = 0;
        exp_s[0] = '{sign:1'b0, exp:8'd100, mant:16'h8000, zero:1'b0, uflow:1'b0};
        exp_s[1] = '{sign:1'b1, exp:8'd99,  mant:16'h8000, zero:1'b0, uflow:1'b0};
        exp_s[2] = '{sign:1'b0, exp:8'd89,  mant:16'h9800, zero:1'b0, uflow:1'b0};
        exp_s[3] = '{sign:1'b1, exp:8'd85,  mant:16'h8000, zero:1'b0, uflow:1'b0};
        exp_s[4] = '{sign:1'b0, exp:8'd0,   mant:16'h0000, zero:1'b1, uflow:1'b0};
        exp_s[5] = '{sign:1'b1, exp:8'd92,  mant:16'hF000, zero:1'b0, uflow:1'b0};
        exp_s[6] = '{sign:1'b0, exp:8'd97,  mant:16'h91A0, zero:1'b0, uflow:1'b0};
        exp_s[7] = '{sign:1'b1, exp:8'd96,  mant:16'hABC0, zero:1'b0, uflow:1'b0};
        held = '0;
        while (out_idx < 8 && cyc < 60) begin
            @(posedge clk); #1;
            out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            if (in_idx < 8) begin
                in_valid = 1'b1;
                in_sign  = in_idx[0];
                in_exp   = 8'd100;
                in_mant  = mants[in_idx];
            end else begin
                in_valid = 1'b0;
            end
            #4;
            got     = {out_sign, out_exp, out_mant, out_zero, out_uflow};
            exp_rdy = !(((in_idx - out_idx) == 2) && !out_ready);
            tests_run++;
            if (in_ready !== exp_rdy) begin
                tests_failed++;
                $display("FAIL stream_in_ready cyc=%0d: got %b, required %b", cyc, in_ready, exp_rdy);
            end
            if (stalled) begin
                tests_run++;
                if (out_valid !== 1'b1 || got !== held) begin
                    tests_failed++;
                    $display("FAIL stream_stall_hold cyc=%0d: valid=%b out=%h, required 1 %h",
                             cyc, out_valid, got, held);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                tests_run++;
                if (out_idx >= 8 || got !== exp_s[out_idx]) begin
                    tests_failed++;
                    $display("FAIL stream_beat[%0d]: got %h, required %h",
                             out_idx, got, (out_idx < 8) ? exp_s[out_idx] : '0);
                end
                out_idx++;
            end
            stalled = (out_valid === 1'b1) && !out_ready;
            held    = got;
            if (in_valid && in_ready === 1'b1) in_idx++;
            cyc++;
        end
        tests_run++;
        if (out_idx != 8 || in_idx != 8) begin
            tests_failed++;
            $display("FAIL stream_count: accepted %0d delivered %0d, required 8 8", in_idx, out_idx);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #5;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stream_no_dup: out_valid=%b after drain, required 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic      ve, vl;
        norm_res_t got;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sign   = 1'b1;
        in_exp    = 8'd100;
        in_mant   = 16'h4000;
        @(posedge clk); #1;
        in_mant = 16'h2000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #3;
        tests_run++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_full: out_valid=%b in_ready=%b, required 1 0", out_valid, in_ready);
        end
        rst_n = 1'b0;
        #1;
        got = {out_sign, out_exp, out_mant, out_zero, out_uflow};
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || got !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset_async: out_valid=%b in_ready=%b out=%h, required 0 1 0",
                     out_valid, in_ready, got);
        end
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        run_beat(1'b0, 8'd20, 16'h0300, ve, vl, got);
        tests_run++;
        if (ve !== 1'b0 || vl !== 1'b1 ||
            got !== '{sign:1'b0, exp:8'd14, mant:16'hC000, zero:1'b0, uflow:1'b0}) begin
            tests_failed++;
            $display("FAIL post_reset_beat: v1=%b v2=%b out=%h, required 0 1 %h",
                     ve, vl, got, norm_res_t'({1'b0, 8'd14, 16'hC000, 1'b0, 1'b0}));
        end
        @(posedge clk); #5;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_no_stale: out_valid=%b, required 0", out_valid);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_mant   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #5;
        test_reset();
        test_values();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
